// File: rtl/act_pkg.sv
// Shared constants, mode encoding and the tanh table contents for the
// activation lookup pipeline. Inputs are signed Q3.5 (step 1/32) and
// outputs signed Q0.7.
package act_pkg;

    localparam int ACT_IN_W       = 8;
    localparam int ACT_IN_FRAC    = 5;
    localparam int ACT_OUT_FRAC   = 7;
    localparam int ACT_LUT_DEPTH  = 256;
    localparam int ACT_LUT_OFFSET = 128;
    localparam int ACT_ADDR_W     = $clog2(ACT_LUT_DEPTH);
    localparam int ACT_OUT_MAX    = (1 << ACT_OUT_FRAC) - 1;

    typedef enum logic {
        ACT_TANH    = 1'b0,
        ACT_SIGMOID = 1'b1
    } act_mode_e;

    // round(128 * tanh(k / 2**ACT_IN_FRAC)) for k = 0..127; the curve is odd,
    // so one magnitude table serves both halves of the signed index range.
    localparam logic [0:127][7:0] ACT_MAG = {
        8'd0,   8'd4,   8'd8,   8'd12,  8'd16,  8'd20,  8'd24,  8'd28,  8'd31,  8'd35,
        8'd39,  8'd42,  8'd46,  8'd49,  8'd53,  8'd56,  8'd59,  8'd62,  8'd65,  8'd68,
        8'd71,  8'd74,  8'd76,  8'd79,  8'd81,  8'd84,  8'd86,  8'd88,  8'd90,  8'd92,
        8'd94,  8'd96,  8'd97,  8'd99,  8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd107,
        8'd109, 8'd110, 8'd111, 8'd112, 8'd113, 8'd113, 8'd114, 8'd115, 8'd116, 8'd117,
        8'd117, 8'd118, 8'd118, 8'd119, 8'd120, 8'd120, 8'd120, 8'd121, 8'd121, 8'd122,
        8'd122, 8'd122, 8'd123, 8'd123, 8'd123, 8'd124, 8'd124, 8'd124, 8'd124, 8'd125,
        8'd125, 8'd125, 8'd125, 8'd125, 8'd126, 8'd126, 8'd126, 8'd126, 8'd126, 8'd126,
        8'd126, 8'd126, 8'd126,
        {17{8'd127}},
        {28{8'd128}}
    };

    // Magnitude for distance k = 0..128 from the table centre.
    function automatic logic [7:0] act_tanh_mag(input logic [ACT_ADDR_W-1:0] k);
        if (k[ACT_ADDR_W-1])
            return 8'd128;
        return ACT_MAG[k[ACT_ADDR_W-2:0]];
    endfunction

    // Signed table entry T[idx]; the positive end saturates to +127.
    function automatic logic signed [ACT_OUT_FRAC:0] act_tanh_entry(input logic [ACT_ADDR_W-1:0] idx);
        logic [7:0] mag;
        if (idx >= ACT_ADDR_W'(ACT_LUT_OFFSET)) begin
            mag = act_tanh_mag(idx - ACT_ADDR_W'(ACT_LUT_OFFSET));
            return (mag > 8'(ACT_OUT_MAX)) ? 8'sd127 : $signed(mag);
        end
        mag = act_tanh_mag(ACT_ADDR_W'(ACT_LUT_OFFSET) - idx);
        return $signed(8'd0 - mag);
    endfunction

endpackage

// File: rtl/tanh_rom.sv
// One-lane 256x8 tanh table with a registered, enabled read port.
module tanh_rom
    import act_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic [ACT_ADDR_W-1:0]          addr,
    output logic signed [ACT_OUT_FRAC:0]   q
);

    // Registered lookup; the read data holds whenever the pipeline stalls.
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= act_tanh_entry(addr);
    end

endmodule

// File: rtl/activation_lut_pipe.sv
// Two-stage, LANES-wide tanh/sigmoid lookup pipeline with valid/ready flow
// control. S1 is the registered table read, S2 the mode post-processing.
// Optional feature macro: ACT_LUT_SIGMOID_EN (adds per-beat sigmoid mode).
module activation_lut_pipe
    import act_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ACT_IN_W*LANES-1:0]    in_data,
    input  logic                         in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACT_IN_W*LANES-1:0]    out_data
);

    logic                                  adv;
    logic                                  s1_valid;
    logic [LANES-1:0][ACT_OUT_FRAC:0]      t_q;
    logic [LANES-1:0][ACT_OUT_FRAC:0]      lane_post;

    // Both stages move together; a stalled output freezes the whole pipe.
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv && !reset;

    // S1 valid: a non-valid input at an advancing edge becomes a bubble.
    always_ff @(posedge clk) begin
        if (reset)
            s1_valid <= 1'b0;
        else if (adv)
            s1_valid <= in_valid;
    end

`ifdef ACT_LUT_SIGMOID_EN
    act_mode_e s1_mode;

    // S1 mode travels alongside the table read so mixed-mode beats stay paired.
    always_ff @(posedge clk) begin
        if (reset)
            s1_mode <= ACT_TANH;
        else if (adv)
            s1_mode <= act_mode_e'(in_mode);
    end
`else
    logic unused_mode;
    assign unused_mode = in_mode;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [ACT_IN_W-1:0] x;
        logic [ACT_ADDR_W-1:0]      addr;

        assign x = in_data[ACT_IN_W*g +: ACT_IN_W];

`ifdef ACT_LUT_SIGMOID_EN
        logic [8:0] sig_sum;

        // Sigmoid halves the input range: index = floor(x/2) + 128.
        assign addr = (in_mode == ACT_SIGMOID)
                    ? ACT_ADDR_W'(x >>> 1) + ACT_ADDR_W'(ACT_LUT_OFFSET)
                    : ACT_ADDR_W'(x) + ACT_ADDR_W'(ACT_LUT_OFFSET);

        // (T + 128) >> 1 in 9 bits; the sum spans 0..255 and never wraps.
        assign sig_sum      = {t_q[g][ACT_OUT_FRAC], t_q[g]} + 9'(ACT_LUT_OFFSET);
        assign lane_post[g] = (s1_mode == ACT_SIGMOID) ? 8'(sig_sum >> 1) : t_q[g];
`else
        assign addr         = ACT_ADDR_W'(x) + ACT_ADDR_W'(ACT_LUT_OFFSET);
        assign lane_post[g] = t_q[g];
`endif

        tanh_rom u_rom (
            .clk   (clk),
            .reset (reset),
            .en    (adv),
            .addr  (addr),
            .q     (t_q[g])
        );
    end

    // S2 output register; holds while the consumer back-pressures.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= s1_valid;
            out_data  <= lane_post;
        end
    end

endmodule

// File: tb/tb_activation_lut_pipe.sv
// Self-checking bench for activation_lut_pipe (LANES = 4). Expected values
// come from real-valued tanh and a two-slot delay-line model of the pipe.
module tb_activation_lut_pipe;

    localparam int LANES = 4;
    localparam int W     = 8 * LANES;
`ifdef ACT_LUT_SIGMOID_EN
    localparam bit SIG_EN = 1'b1;
`else
    localparam bit SIG_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        bit           v;
        logic [W-1:0] d;
    } slot_t;

    slot_t pipe[$];

    activation_lut_pipe #(.LANES(LANES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // T[i] = clamp(round(128 * tanh((i - 128) / 32)), -128, 127)
    function automatic int tanh_table(input int i);
        real r;
        int  v;
        r = 128.0 * $tanh(real'(i - 128) / 32.0);
        v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    function automatic int lane_ref(input int x, input bit sig);
        int h;
        if (!sig)
            return tanh_table(x + 128);
        h = (x >= 0) ? x / 2 : -((1 - x) / 2);
        return (tanh_table(h + 128) + 128) / 2;
    endfunction

    function automatic logic [W-1:0] beat_ref(input logic [W-1:0] data, input bit mode);
        logic [W-1:0] r;
        logic [7:0]   b;
        for (int k = 0; k < LANES; k++) begin
            b = data[8*k +: 8];
            r[8*k +: 8] = 8'(lane_ref(int'($signed(b)), SIG_EN && mode));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t bubble();
        slot_t s;
        s.v = 1'b0;
        s.d = '0;
        return s;
    endfunction

    // One clock: drive inputs, check in_ready, update the model, check outputs.
    // acc/del report the handshakes the DUT showed just before the edge.
    task automatic cycle(input bit rst, input bit iv, input bit md, input logic [W-1:0] dat,
                         input bit ordy, output bit acc, output bit del);
        bit    adv_m;
        bit    exp_rdy;
        slot_t s;
        reset     = rst;
        in_valid  = iv;
        in_mode   = md;
        in_data   = dat;
        out_ready = ordy;
        #1;
        adv_m   = ordy || !pipe[0].v;
        exp_rdy = adv_m && !rst;
        check("in_ready", W'(in_ready), W'(exp_rdy));
        acc = iv && in_ready;
        del = out_valid && ordy && !rst;
        if (rst) begin
            pipe.delete();
            pipe.push_back(bubble());
            pipe.push_back(bubble());
        end else if (adv_m) begin
            s.v = iv;
            s.d = beat_ref(dat, md);
            void'(pipe.pop_front());
            pipe.push_back(s);
        end
        @(posedge clk);
        #1;
        check("out_valid", W'(out_valid), W'(pipe[0].v));
        if (pipe[0].v)
            check("out_data", out_data, pipe[0].d);
        if (rst)
            check("rst_data", out_data, '0);
    endtask

    initial begin
        bit           a;
        bit           d;
        int           idx;
        int           dels;
        int           tries;
        logic [W-1:0] sd [3];
        bit           sm [3];

        pipe.push_back(bubble());
        pipe.push_back(bubble());

        // Reset state
        cycle(1, 0, 0, '0, 1, a, d);
        cycle(1, 0, 0, '0, 1, a, d);

        // Tanh lanes {0, 32, -32, 127}; result visible after the second edge
        cycle(0, 1, 0, {8'h7F, 8'hE0, 8'h20, 8'h00}, 1, a, d);
        check("tanh_accept", W'(a), W'(1));
        cycle(0, 0, 0, '0, 1, a, d);
        check("tanh_example", out_data, 32'h7F9F_6100);
        cycle(0, 0, 0, '0, 1, a, d);

        // Sigmoid lanes {0, -128, 127, 32}
        cycle(0, 1, 1, {8'h20, 8'h7F, 8'h80, 8'h00}, 1, a, d);
        cycle(0, 0, 0, '0, 1, a, d);
`ifdef ACT_LUT_SIGMOID_EN
        check("sig_zero_lane", W'(out_data[7:0]), W'(64));
`else
        check("mode_ignored_zero", W'(out_data[7:0]), W'(0));
`endif
        cycle(0, 0, 0, '0, 1, a, d);

        // Back-to-back tanh 0 then sigmoid 0, no bubble between them
        cycle(0, 1, 0, '0, 1, a, d);
        cycle(0, 1, 1, '0, 1, a, d);
        check("b2b_first", out_data, '0);
        cycle(0, 0, 0, '0, 1, a, d);
        check("b2b_second_valid", W'(out_valid), W'(1));
        cycle(0, 0, 0, '0, 1, a, d);

        // Stall 5 cycles with 3 beats offered
        for (int i = 0; i < 3; i++) begin
            sd[i] = W'($urandom);
            sm[i] = 1'($urandom);
        end
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            cycle(0, idx < 3, (idx < 3) ? sm[idx] : 1'b0, (idx < 3) ? sd[idx] : '0, 0, a, d);
            if (a) idx++;
        end
        check("stall_accepts", W'(idx), W'(2));
        dels  = 0;
        tries = 0;
        while (idx < 3 && tries < 20) begin
            cycle(0, 1, sm[idx], sd[idx], 1, a, d);
            if (a) idx++;
            if (d) dels++;
            tries++;
        end
        check("release_accepts", W'(idx), W'(3));
        for (int c = 0; c < 3; c++) begin
            cycle(0, 0, 0, '0, 1, a, d);
            if (d) dels++;
        end
        check("release_delivered", W'(dels), W'(3));

        // Reset with two beats in flight
        cycle(0, 1, 0, W'($urandom), 1, a, d);
        cycle(0, 1, 1, W'($urandom), 1, a, d);
        cycle(1, 1, 0, W'($urandom), 1, a, d);
        dels = 0;
        for (int c = 0; c < 3; c++) begin
            cycle(0, 0, 0, '0, 1, a, d);
            if (d) dels++;
        end
        check("no_stale_after_reset", W'(dels), W'(0));

        // Every table index, both modes
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 64; i++)
                cycle(0, 1, m[0], {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1, a, d);

        // Random traffic with random back-pressure and occasional reset
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                  W'($urandom), $urandom_range(0, 3) != 0, a, d);

        for (int c = 0; c < 3; c++)
            cycle(0, 0, 0, '0, 1, a, d);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
